dm_bytelane: RTL

Parametrised data memory for the pipelined MIPS core's MEM stage: synchronous byte/half/word writes, a one-cycle registered read with sign/zero extension, and misalignment detection. On reset it walks the array and clears it one word per cycle, signalling `busy` while it does so. It replaces the word-only, combinational-write data memory.

---
 rtl/dm_bytelane.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dm_bytelane.sv
`default_nettype none
// ============================================================================
// Module   : dm_bytelane
// Brief    : MEM-stage data memory with byte/half/word lanes, registered
//            sign/zero-extending reads, misalignment flag and reset clear.
// Revision : 1.0 - initial release
// ============================================================================
module dm_bytelane #(
   parameter int DEPTH      = 1024,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr_i,
   input  logic        MemWrite_i,
   input  logic        MemRead_i,
   input  logic [1:0]  size_i,
   input  logic        sign_ext_i,
   input  logic [31:0] din_i,
   output logic [31:0] dmread_o,
   output logic        rvalid_o,
   output logic        misalign_o,
   output logic        busy_o
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] clr_idx_q, clr_idx_d;
   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   dmread_q;
   logic          rvalid_q;
   logic          misalign_q;

   logic [AW-1:0] w_idx;
   logic          w_legal;
   logic          w_req;
   logic          w_rd_acc;
   logic          w_wr_acc;
   logic          w_clr_we;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic [31:0]   w_rword;
   logic [7:0]    w_rbyte;
   logic [15:0]   w_rhalf;
   logic [31:0]   w_rdata;
   logic          unused_addr_hi;

   assign w_idx          = addr_i[AW+1:2];
   assign unused_addr_hi = ^addr_i[31:AW+2];
   assign busy_o         = (state_q == S_CLEAR);

   always_comb begin
      w_legal = 1'b0;
      case (size_i)
         2'b00:   w_legal = 1'b1;
         2'b01:   w_legal = ~addr_i[0];
         2'b10:   w_legal = (addr_i[1:0] == 2'b00);
         default: w_legal = 1'b0;
      endcase
   end

   assign w_req    = !rst && (state_q == S_IDLE) && (MemRead_i || MemWrite_i);
   assign w_rd_acc = w_req && w_legal && MemRead_i;
   assign w_wr_acc = w_req && w_legal && MemWrite_i;
   assign w_clr_we = !rst && (state_q == S_CLEAR);

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      if (state_q == S_CLEAR) begin
         clr_idx_d = clr_idx_q + AW'(1);
         if (clr_idx_q == AW'(DEPTH - 1)) begin
            state_d = S_IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= INIT_CLEAR ? S_CLEAR : S_IDLE;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   // Narrow stores are replicated across the word; byte enables pick the lanes.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = din_i;
      case (size_i)
         2'b00: begin
            w_be    = 4'b0001 << addr_i[1:0];
            w_wdata = {4{din_i[7:0]}};
         end
         2'b01: begin
            w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{din_i[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = din_i;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         mem_q[clr_idx_q] <= '0;
      end else if (w_wr_acc) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) begin
               mem_q[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
         end
      end
   end

   // Read sees pre-write contents because the array updates non-blocking.
   assign w_rword = mem_q[w_idx];
   assign w_rbyte = w_rword[{addr_i[1:0], 3'b000} +: 8];
   assign w_rhalf = addr_i[1] ? w_rword[31:16] : w_rword[15:0];

   always_comb begin
      w_rdata = w_rword;
      case (size_i)
         2'b00:   w_rdata = {{24{sign_ext_i & w_rbyte[7]}}, w_rbyte};
         2'b01:   w_rdata = {{16{sign_ext_i & w_rhalf[15]}}, w_rhalf};
         default: w_rdata = w_rword;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dmread_q   <= '0;
         rvalid_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         rvalid_q   <= w_rd_acc;
         misalign_q <= w_req && !w_legal;
         if (w_rd_acc) begin
            dmread_q <= w_rdata;
         end
      end
   end

   assign dmread_o   = dmread_q;
   assign rvalid_o   = rvalid_q;
   assign misalign_o = misalign_q;

endmodule
`default_nettype wire
